// File: rtl/cv32e41s_pkg.sv
// Shared types and constants for the cv32e41s table-jump controller.
// Holds the FSM state enum, the fault cause codes and the jump-target helper.
package cv32e41s_pkg;

  typedef enum logic [2:0] {
    TBLJMP_IDLE  = 3'd0,
    TBLJMP_REQ   = 3'd1,
    TBLJMP_WAIT  = 3'd2,
    TBLJMP_DRAIN = 3'd3,
    TBLJMP_DONE  = 3'd4
  } tbljmp_state_e;

  localparam logic [1:0] TBLJMP_EXC_MISALIGN = 2'b01;
  localparam logic [1:0] TBLJMP_EXC_BUSERR   = 2'b10;
  localparam logic [1:0] TBLJMP_EXC_ZERO     = 2'b11;

  // Table entries may carry a mode flag in bit 0; the fetch target must not.
  function automatic logic [31:0] tbljmp_target(input logic [31:0] entry,
                                                input bit          clear_lsb);
    return clear_lsb ? {entry[31:1], 1'b0} : entry;
  endfunction

endpackage

// File: rtl/cv32e41s_tbljmp_ctrl.sv
// Table-jump controller: fetches a jump-table entry over OBI and redirects the PC.
// Define CV32E41S_TBLJMP_ZERO_CHECK_EN to fault on a zero table entry.
module cv32e41s_tbljmp_ctrl
  import cv32e41s_pkg::*;
#(
  parameter bit CLEAR_LSB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        tbljmp_valid_i,
  output logic        tbljmp_ready_o,
  input  logic [31:0] tbljmp_addr_i,
  input  logic        kill_i,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        pc_set_o,
  output logic [31:0] pc_target_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o,
  output logic        busy_o
);

  tbljmp_state_e state_q, state_d;
  logic [31:0]   addr_q;
  logic [31:0]   target_q;
  logic [1:0]    cause_q;
  logic          done_exc_q;

  logic accept;
  logic misaligned;
  logic zero_entry;
  logic resp_take;
  logic in_done;

  assign accept     = tbljmp_valid_i && tbljmp_ready_o && !kill_i;
  assign misaligned = (tbljmp_addr_i[1:0] != 2'b00);
  assign resp_take  = (state_q == TBLJMP_WAIT) && mem_rvalid_i && !kill_i;

`ifdef CV32E41S_TBLJMP_ZERO_CHECK_EN
  assign zero_entry = (mem_rdata_i == 32'h0000_0000);
`else
  assign zero_entry = 1'b0;
`endif

  // A granted request is always followed by a response, so a kill after grant
  // must pass through DRAIN to keep the single outstanding transaction accounted for.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TBLJMP_IDLE: begin
        if (accept) begin
          state_d = misaligned ? TBLJMP_DONE : TBLJMP_REQ;
        end
      end
      TBLJMP_REQ: begin
        if (mem_gnt_i) begin
          state_d = kill_i ? TBLJMP_DRAIN : TBLJMP_WAIT;
        end else if (kill_i) begin
          state_d = TBLJMP_IDLE;
        end
      end
      TBLJMP_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = kill_i ? TBLJMP_IDLE : TBLJMP_DONE;
        end else if (kill_i) begin
          state_d = TBLJMP_DRAIN;
        end
      end
      TBLJMP_DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = TBLJMP_IDLE;
        end
      end
      TBLJMP_DONE: begin
        state_d = TBLJMP_IDLE;
      end
      default: begin
        state_d = TBLJMP_IDLE;
      end
    endcase
  end

  // DONE reports either a redirect or a fault, selected by done_exc_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TBLJMP_IDLE;
      addr_q     <= 32'h0000_0000;
      target_q   <= 32'h0000_0000;
      cause_q    <= 2'b00;
      done_exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= tbljmp_addr_i;
        done_exc_q <= misaligned;
        if (misaligned) begin
          cause_q <= TBLJMP_EXC_MISALIGN;
        end
      end
      if (resp_take) begin
        if (mem_err_i) begin
          done_exc_q <= 1'b1;
          cause_q    <= TBLJMP_EXC_BUSERR;
        end else if (zero_entry) begin
          done_exc_q <= 1'b1;
          cause_q    <= TBLJMP_EXC_ZERO;
        end else begin
          done_exc_q <= 1'b0;
          target_q   <= tbljmp_target(mem_rdata_i, CLEAR_LSB);
        end
      end
    end
  end

  assign in_done        = (state_q == TBLJMP_DONE);
  assign tbljmp_ready_o = (state_q == TBLJMP_IDLE);
  assign busy_o         = (state_q != TBLJMP_IDLE);
  assign mem_req_o      = (state_q == TBLJMP_REQ);
  assign mem_addr_o     = addr_q;
  assign pc_target_o    = target_q;
  assign exc_cause_o    = cause_q;
  assign pc_set_o       = in_done && !done_exc_q && !kill_i;
  assign exc_o          = in_done &&  done_exc_q && !kill_i;

endmodule

// File: tb/tb_cv32e41s_tbljmp_ctrl.sv
// Scoreboard bench for cv32e41s_tbljmp_ctrl: directed table jumps, then random ones.
// The expected outcome of each accepted jump is queued and matched by a monitor.
module tb_cv32e41s_tbljmp_ctrl;

  logic        clk;
  logic        rst;
  logic        tbljmp_valid_i;
  logic        tbljmp_ready_o;
  logic [31:0] tbljmp_addr_i;
  logic        kill_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        pc_set_o;
  logic [31:0] pc_target_o;
  logic        exc_o;
  logic [1:0]  exc_cause_o;
  logic        busy_o;

  typedef struct {
    bit          is_exc;
    logic [1:0]  cause;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  cv32e41s_tbljmp_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .tbljmp_valid_i (tbljmp_valid_i),
    .tbljmp_ready_o (tbljmp_ready_o),
    .tbljmp_addr_i  (tbljmp_addr_i),
    .kill_i         (kill_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .pc_set_o       (pc_set_o),
    .pc_target_o    (pc_target_o),
    .exc_o          (exc_o),
    .exc_cause_o    (exc_cause_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and return all inputs to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    tbljmp_valid_i = 1'b0;
    kill_i         = 1'b0;
    mem_gnt_i      = 1'b0;
    mem_rvalid_i   = 1'b0;
    mem_err_i      = 1'b0;
    mem_rdata_i    = $urandom();
  endtask

  // Outcome of a table jump that is not killed.
  function automatic exp_t model(input logic [31:0] addr, input logic err, input logic [31:0] data);
    exp_t e;
    e.is_exc = 1'b0;
    e.cause  = 2'b00;
    e.target = 32'h0;
    if (addr[1:0] != 2'b00) begin
      e.is_exc = 1'b1;
      e.cause  = 2'b01;
    end else if (err) begin
      e.is_exc = 1'b1;
      e.cause  = 2'b10;
`ifdef CV32E41S_TBLJMP_ZERO_CHECK_EN
    end else if (data == 32'h0) begin
      e.is_exc = 1'b1;
      e.cause  = 2'b11;
`endif
    end else begin
      e.target = data & 32'hFFFF_FFFE;
    end
    return e;
  endfunction

  // kph: 0 no kill, 1 kill in REQ before grant, 2 kill in WAIT without rvalid,
  // 3 kill in WAIT with rvalid, 4 kill in DONE, 5 kill in REQ with grant.
  task automatic applyStimulus(input logic [31:0] addr, input int g, input int r,
                               input logic err, input logic [31:0] data, input int kph);
    int  n;
    bit  abort;
    next_cycle();
    n = 0;
    while (!tbljmp_ready_o && n < 20) begin
      next_cycle();
      n++;
    end
    check_bit("ready_before_issue", tbljmp_ready_o, 1'b1);
    if (!tbljmp_ready_o) return;
    tbljmp_valid_i = 1'b1;
    tbljmp_addr_i  = addr;
    if (kph == 0) exp_q.push_back(model(addr, err, data));

    if (addr[1:0] != 2'b00) begin
      next_cycle();
      if (kph == 4) kill_i = 1'b1;
      #2;
      check_bit("misalign_no_req", mem_req_o, 1'b0);
      check_bit("misalign_exc_timing", exc_o, kph != 4);
      return;
    end

    abort = 1'b0;
    for (int i = 0; i <= g; i++) begin
      next_cycle();
      check_bit("req_held", mem_req_o, 1'b1);
      check_word("req_addr_held", mem_addr_o, addr);
      if (kph == 1) begin
        kill_i = 1'b1;
        abort  = 1'b1;
        break;
      end
      if (i == g) begin
        mem_gnt_i = 1'b1;
        if (kph == 5) kill_i = 1'b1;
      end
    end
    if (abort) begin
      next_cycle();
      check_bit("kill_req_drop", mem_req_o, 1'b0);
      check_bit("kill_req_idle", busy_o, 1'b0);
      return;
    end

    for (int j = 0; j <= r; j++) begin
      next_cycle();
      check_bit("no_second_req", mem_req_o, 1'b0);
      if (kph == 5 || (kph == 2 && j > 0)) check_bit("drain_ready_low", tbljmp_ready_o, 1'b0);
      if (j == r) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        mem_err_i    = err;
      end
      if ((kph == 2 && j == 0) || (kph == 3 && j == r)) kill_i = 1'b1;
    end

    next_cycle();
    if (kph == 2 || kph == 3 || kph == 5) begin
      check_bit("ready_after_rvalid", tbljmp_ready_o, 1'b1);
    end else begin
      if (kph == 4) kill_i = 1'b1;
      #2;
      check_bit("done_latency", pc_set_o | exc_o, kph != 4);
    end
  endtask

  // Monitor: every redirect or fault must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (pc_set_o || exc_o)) begin
      check_bit("pc_exc_exclusive", pc_set_o & exc_o, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got pc_set=%b exc=%b expected none at %0t",
                 pc_set_o, exc_o, $time);
      end else begin
        e = exp_q.pop_front();
        check_bit("output_kind", exc_o, e.is_exc);
        if (e.is_exc) check_word("exc_cause", {30'b0, exc_cause_o}, {30'b0, e.cause});
        else          check_word("pc_target", pc_target_o, e.target);
      end
    end
  end

  task automatic checkOutput();
    check_word("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          g;
    int          r;
    int          k;
    logic        er;

    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    tbljmp_valid_i = 1'b0;
    tbljmp_addr_i  = 32'h0;
    kill_i         = 1'b0;
    mem_gnt_i      = 1'b0;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = 32'h0;
    mem_err_i      = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_bit("rst_mem_req", mem_req_o, 1'b0);
    check_bit("rst_pc_set", pc_set_o, 1'b0);
    check_bit("rst_exc", exc_o, 1'b0);
    check_bit("rst_busy", busy_o, 1'b0);
    check_word("rst_mem_addr", mem_addr_o, 32'h0);
    check_word("rst_pc_target", pc_target_o, 32'h0);
    check_word("rst_exc_cause", {30'b0, exc_cause_o}, 32'h0);
    rst = 1'b0;

    $display("[TB] directed table jumps");
    applyStimulus(32'h0000_1004, 0, 0, 1'b0, 32'h0000_2001, 0);
    applyStimulus(32'h0000_1006, 0, 0, 1'b0, 32'h0000_1234, 0);
    applyStimulus(32'h0000_1008, 4, 1, 1'b0, 32'h0000_3000, 0);
    applyStimulus(32'h0000_100C, 0, 3, 1'b0, 32'h0000_4444, 2);
    applyStimulus(32'h0000_1010, 1, 0, 1'b1, 32'h0000_5555, 0);
    applyStimulus(32'h0000_1014, 0, 0, 1'b0, 32'h0000_0000, 0);
    applyStimulus(32'h0000_1018, 2, 0, 1'b0, 32'h0000_0006, 1);
    applyStimulus(32'h0000_101C, 0, 2, 1'b0, 32'h0000_0007, 3);
    applyStimulus(32'h0000_1020, 1, 1, 1'b0, 32'h0000_0009, 4);
    applyStimulus(32'h0000_1024, 2, 2, 1'b0, 32'h0000_000B, 5);
    applyStimulus(32'h0000_1028, 0, 0, 1'b0, 32'h8000_0003, 0);

    $display("[TB] reset in the middle of a transaction");
    next_cycle();
    tbljmp_valid_i = 1'b1;
    tbljmp_addr_i  = 32'h0000_2000;
    next_cycle();
    mem_gnt_i = 1'b1;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_bit("midrst_busy", busy_o, 1'b0);
    check_bit("midrst_req", mem_req_o, 1'b0);
    check_word("midrst_addr", mem_addr_o, 32'h0);

    $display("[TB] random table jumps");
    for (int t = 0; t < 300; t++) begin
      a  = ($urandom_range(0, 5) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      d  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      g  = $urandom_range(0, 4);
      r  = $urandom_range(0, 3);
      er = ($urandom_range(0, 5) == 0);
      k  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      if (a[1:0] != 2'b00 && k != 4) k = 0;
      if (k == 1 && g == 0) g = 1;
      if (k == 2 && r == 0) r = 1;
      applyStimulus(a, g, r, er, d, k);
    end

    repeat (3) next_cycle();
    checkOutput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e41s_tbljmp_ctrl.md
CV32E41S_TBLJMP_CTRL -- requirements
Module: cv32e41s_tbljmp_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_LSB, default 1'b1: force bit 0 of the loaded jump target to 0.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port tbljmp_valid_i, input, 1: table jump issued from ID; address is valid.
REQ-005 SHALL have port tbljmp_ready_o, input-side handshake output, 1: block accepts a new table jump.
REQ-006 SHALL have port tbljmp_addr_i, input, 32: table entry address (jump target computed for CT_TBLJMP).
REQ-007 SHALL have port kill_i, input, 1: controller flush; abandon the current table jump.
REQ-008 SHALL have ports mem_req_o (output, 1), mem_addr_o (output, 32), mem_gnt_i (input, 1): OBI-style address phase.
REQ-009 SHALL have ports mem_rvalid_i (input, 1), mem_rdata_i (input, 32), mem_err_i (input, 1): OBI-style response phase.
REQ-010 SHALL have ports pc_set_o (output, 1), pc_target_o (output, 32): one-cycle PC redirect to the loaded entry.
REQ-011 SHALL have ports exc_o (output, 1), exc_cause_o (output, 2): one-cycle fault; 01 misaligned, 10 bus error, 11 zero entry.
REQ-012 SHALL have port busy_o, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, DRAIN, DONE.
REQ-014 SHALL assert tbljmp_ready_o only in IDLE; accept when tbljmp_valid_i && tbljmp_ready_o && !kill_i.
REQ-015 SHALL capture tbljmp_addr_i on acceptance.
REQ-016 On acceptance with addr[1:0]!=0: no memory request; next cycle exc_o=1, exc_cause_o=01; return to IDLE.
REQ-017 On aligned acceptance: go to REQ; mem_req_o=1 with mem_addr_o=captured address; hold both stable until mem_gnt_i.
REQ-018 SHALL leave REQ for WAIT on mem_gnt_i; zero-latency grant means REQ lasts exactly one cycle.
REQ-019 In WAIT: on mem_rvalid_i with mem_err_i=1, pulse exc_o (cause 10); on mem_rvalid_i with mem_err_i=0, register the entry and go to DONE.
REQ-020 In DONE: pulse pc_set_o for one cycle with pc_target_o=entry, bit 0 cleared if CLEAR_LSB; return to IDLE.
REQ-021 Minimum latency from acceptance to pc_set_o: 3 cycles (REQ, WAIT with same-cycle rvalid, DONE).
REQ-022 kill_i in REQ before grant: drop mem_req_o and return to IDLE.
REQ-023 kill_i in REQ with mem_gnt_i in the same cycle, or kill_i in WAIT without rvalid: go to DRAIN.
REQ-024 kill_i in WAIT coincident with mem_rvalid_i: consume the response and return to IDLE.
REQ-025 DRAIN SHALL wait for mem_rvalid_i, discard data and error, then return to IDLE; tbljmp_ready_o stays low.
REQ-026 kill_i in DONE SHALL suppress pc_set_o and exc_o.
REQ-027 pc_set_o and exc_o SHALL never assert in the same cycle.
REQ-028 At most one outstanding memory transaction.

Reset
REQ-029 Reset SHALL set state IDLE; mem_req_o, pc_set_o, exc_o, and busy_o to 0; mem_addr_o, pc_target_o, and exc_cause_o to 0.
REQ-030 Reset mid-transaction SHALL abandon it without draining; the memory side is reset together with the block.

Configuration
REQ-031 With CV32E41S_TBLJMP_ZERO_CHECK_EN defined, a zero entry in WAIT SHALL give exc_o (cause 11) instead of DONE.
REQ-032 Without CV32E41S_TBLJMP_ZERO_CHECK_EN, a zero entry SHALL redirect to 0x0000_0000 like any other entry.

Structure
REQ-033 SHALL place the state enum tbljmp_state_e and the cause constants TBLJMP_EXC_MISALIGN, TBLJMP_EXC_BUSERR, and TBLJMP_EXC_ZERO in cv32e41s_pkg.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Addr 0x0000_1004, grant at once, rvalid next cycle with data 0x0000_2001: pc_set_o=1 with pc_target_o=0x0000_2000, 3 cycles after acceptance.
REQ-036 Addr 0x0000_1006: no mem_req_o; exc_o=1 with cause 01 one cycle later.
REQ-037 Grant delayed 4 cycles: mem_req_o and mem_addr_o stay stable for all 5 cycles.
REQ-038 kill_i one cycle after grant, rvalid 3 cycles later: no pc_set_o; tbljmp_ready_o stays low until the cycle after rvalid.
REQ-039 rvalid with mem_err_i=1: exc_o=1, cause 10, no pc_set_o.
REQ-040 Data 0x0 with the macro defined: exc_o with cause 11; without the macro: pc_set_o with target 0x0.
